// File: rtl/cpu_core.sv
// 8-bit accumulator CPU: 2-byte instructions, fixed 4-cycle fetch/fetch/fetch/execute,
// driving a synchronous RAM whose read data lags the address by one clock.
module cpu_core #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_write,
  input  logic [7:0] mem_rdata,
  output logic [7:0] acc_out,
  output logic [7:0] pc_out,
  output logic       halted
);

  localparam int unsigned DW = 8;
  localparam int unsigned OW = 4;

  localparam logic [OW-1:0] OP_LDI = 4'h1;
  localparam logic [OW-1:0] OP_LDA = 4'h2;
  localparam logic [OW-1:0] OP_STA = 4'h3;
  localparam logic [OW-1:0] OP_ADD = 4'h4;
  localparam logic [OW-1:0] OP_SUB = 4'h5;
  localparam logic [OW-1:0] OP_AND = 4'h6;
  localparam logic [OW-1:0] OP_OR  = 4'h7;
  localparam logic [OW-1:0] OP_XOR = 4'h8;
  localparam logic [OW-1:0] OP_JMP = 4'h9;
  localparam logic [OW-1:0] OP_JZ  = 4'hA;
  localparam logic [OW-1:0] OP_JC  = 4'hB;
  localparam logic [OW-1:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH0 = 3'd0,
    S_FETCH1 = 3'd1,
    S_FETCH2 = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] a_q, a_d;
  logic [OW-1:0] ir_q, ir_d;
  logic [DW-1:0] opr_q, opr_d;
  logic          z_q, z_d;
  logic          c_q, c_d;
  logic          halted_q, halted_d;

  logic [DW:0]   sum_w;
  logic [DW:0]   diff_w;
  logic [DW-1:0] alu_res;
  logic          alu_wr;

  // Carry-out of ADD and borrow of SUB both land in bit DW
  assign sum_w  = {1'b0, a_q} + {1'b0, mem_rdata};
  assign diff_w = {1'b0, a_q} - {1'b0, mem_rdata};

  // Only the opcode nibble is kept; the low nibble of the opcode byte is don't-care
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    a_d       = a_q;
    ir_d      = ir_q;
    opr_d     = opr_q;
    z_d       = z_q;
    c_d       = c_q;
    halted_d  = halted_q;
    mem_addr  = pc_q;
    mem_write = 1'b0;
    alu_res   = a_q;
    alu_wr    = 1'b0;

    case (state_q)
      S_FETCH0: begin
        mem_addr = pc_q;
        state_d  = S_FETCH1;
      end
      S_FETCH1: begin
        mem_addr = pc_q + DW'(1);
        ir_d     = mem_rdata[DW-1:DW-OW];
        state_d  = S_FETCH2;
      end
      S_FETCH2: begin
        mem_addr = mem_rdata;
        opr_d    = mem_rdata;
        pc_d     = pc_q + DW'(2);
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        mem_addr = opr_q;
        state_d  = S_FETCH0;
        case (ir_q)
          OP_LDI: begin alu_res = opr_q;             alu_wr = 1'b1; end
          OP_LDA: begin alu_res = mem_rdata;         alu_wr = 1'b1; end
          OP_STA: mem_write = ~reset;
          OP_ADD: begin
            alu_res = sum_w[DW-1:0];
            alu_wr  = 1'b1;
            c_d     = sum_w[DW];
          end
          OP_SUB: begin
            alu_res = diff_w[DW-1:0];
            alu_wr  = 1'b1;
            c_d     = diff_w[DW];
          end
          OP_AND: begin alu_res = a_q & mem_rdata;   alu_wr = 1'b1; end
          OP_OR:  begin alu_res = a_q | mem_rdata;   alu_wr = 1'b1; end
          OP_XOR: begin alu_res = a_q ^ mem_rdata;   alu_wr = 1'b1; end
          OP_JMP: pc_d = opr_q;
          OP_JZ:  if (z_q) pc_d = opr_q;
          OP_JC:  if (c_q) pc_d = opr_q;
          OP_HLT: begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
          default: ;
        endcase
        if (alu_wr) begin
          a_d = alu_res;
          z_d = (alu_res == '0);
        end
      end
      S_HALT: begin
        mem_addr = pc_q;
        halted_d = 1'b1;
      end
      default: state_d = S_FETCH0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH0;
      pc_q     <= RESET_PC;
      a_q      <= '0;
      ir_q     <= '0;
      opr_q    <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      a_q      <= a_d;
      ir_q     <= ir_d;
      opr_q    <= opr_d;
      z_q      <= z_d;
      c_q      <= c_d;
      halted_q <= halted_d;
    end
  end

  assign mem_wdata = a_q;
  assign acc_out   = a_q;
  assign pc_out    = pc_q;
  assign halted    = halted_q;

endmodule
